alu_pipe: RTL

ALU_PIPE -- requirements
Module: alu_pipe

---
 rtl/alu_pipe_if.sv | 30 +++
 rtl/alu_pipe.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/alu_pipe_if.sv
// Request/result channel of the pipelined ALU: a valid/ready request side
// carrying operands and a valid/ready result side carrying R and its flags.
interface alu_pipe_if #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       ctrl;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [SHW-1:0]   shamt;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] R;
  logic             cout;
  logic             ovf;
  logic             ze;
  logic             err;

  modport master (
    output in_valid, ctrl, A, B, shamt, out_ready,
    input  in_ready, out_valid, R, cout, ovf, ze, err
  );

  modport slave (
    input  in_valid, ctrl, A, B, shamt, out_ready,
    output in_ready, out_valid, R, cout, ovf, ze, err
  );
endinterface

// File: rtl/alu_pipe.sv
// Single-issue ALU: one-cycle latency for all ops except MUL, which runs a
// WIDTH-cycle shift-add sequence. Result and flags are held until taken.
module alu_pipe #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  alu_pipe_if.slave  bus
);

  localparam logic [3:0] OP_AND  = 4'd0;
  localparam logic [3:0] OP_OR   = 4'd1;
  localparam logic [3:0] OP_ADD  = 4'd2;
  localparam logic [3:0] OP_SLT  = 4'd3;
  localparam logic [3:0] OP_ADDU = 4'd4;
  localparam logic [3:0] OP_SLL  = 4'd5;
  localparam logic [3:0] OP_SUB  = 4'd6;
  localparam logic [3:0] OP_SLTU = 4'd7;
  localparam logic [3:0] OP_SRL  = 4'd8;
  localparam logic [3:0] OP_SRA  = 4'd9;
  localparam logic [3:0] OP_XOR  = 4'd10;
  localparam logic [3:0] OP_NOR  = 4'd11;
  localparam logic [3:0] OP_MUL  = 4'd12;
  localparam logic [3:0] OP_SUBU = 4'd13;

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    MUL_BUSY = 1'b1
  } state_t;

  state_t           state;
  logic [SHW-1:0]   cnt;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_nxt;

  logic             out_valid_q;
  logic [WIDTH-1:0] r_q;
  logic             cout_q;
  logic             ovf_q;
  logic             ze_q;
  logic             err_q;

  logic             accept;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic             add_ovf;
  logic             sub_ovf;
  logic [WIDTH-1:0] alu_r;
  logic             alu_c;
  logic             alu_o;
  logic             alu_e;

  assign bus.in_ready  = rst_n && (state == IDLE) && (!out_valid_q || bus.out_ready);
  assign bus.out_valid = out_valid_q;
  assign bus.R         = r_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;
  assign bus.ze        = ze_q;
  assign bus.err       = err_q;

  assign accept = bus.in_valid && bus.in_ready;

  // The extra top bit of diff is the borrow, i.e. set exactly when A < B unsigned.
  assign sum     = {1'b0, bus.A} + {1'b0, bus.B};
  assign diff    = {1'b0, bus.A} - {1'b0, bus.B};
  assign add_ovf = (bus.A[WIDTH-1] == bus.B[WIDTH-1]) && (sum[WIDTH-1] != bus.A[WIDTH-1]);
  assign sub_ovf = (bus.A[WIDTH-1] != bus.B[WIDTH-1]) && (diff[WIDTH-1] != bus.A[WIDTH-1]);

  assign acc_nxt = mplier[0] ? (acc + mcand) : acc;

  always_comb begin
    alu_r = '0;
    alu_c = 1'b0;
    alu_o = 1'b0;
    alu_e = 1'b0;
    case (bus.ctrl)
      OP_AND:  alu_r = bus.A & bus.B;
      OP_OR:   alu_r = bus.A | bus.B;
      OP_ADD: begin
        alu_r = sum[WIDTH-1:0];
        alu_c = sum[WIDTH];
        alu_o = add_ovf;
      end
      OP_SLT:  alu_r = {{(WIDTH-1){1'b0}}, ($signed(bus.A) < $signed(bus.B))};
      OP_ADDU: begin
        alu_r = sum[WIDTH-1:0];
        alu_c = sum[WIDTH];
      end
      OP_SLL:  alu_r = bus.A << bus.shamt;
      OP_SUB: begin
        alu_r = diff[WIDTH-1:0];
        alu_c = diff[WIDTH];
        alu_o = sub_ovf;
      end
      OP_SLTU: alu_r = {{(WIDTH-1){1'b0}}, (bus.A < bus.B)};
      OP_SRL:  alu_r = bus.A >> bus.shamt;
      OP_SRA:  alu_r = $signed(bus.A) >>> bus.shamt;
      OP_XOR:  alu_r = bus.A ^ bus.B;
      OP_NOR:  alu_r = ~(bus.A | bus.B);
      OP_MUL:  alu_r = '0;
      OP_SUBU: begin
        alu_r = diff[WIDTH-1:0];
        alu_c = diff[WIDTH];
      end
      default: alu_e = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      mcand       <= '0;
      mplier      <= '0;
      acc         <= '0;
      out_valid_q <= 1'b0;
      r_q         <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      ze_q        <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      // Drain first; a result landing on the same edge overrides the clear below.
      if (out_valid_q && bus.out_ready)
        out_valid_q <= 1'b0;

      case (state)
        IDLE: begin
          if (accept) begin
            if (bus.ctrl == OP_MUL) begin
              state  <= MUL_BUSY;
              cnt    <= SHW'(WIDTH - 1);
              acc    <= '0;
              mcand  <= bus.A;
              mplier <= bus.B;
            end else begin
              out_valid_q <= 1'b1;
              r_q         <= alu_r;
              cout_q      <= alu_c;
              ovf_q       <= alu_o;
              ze_q        <= (alu_r == '0);
              err_q       <= alu_e;
            end
          end
        end
        MUL_BUSY: begin
          acc    <= acc_nxt;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          if (cnt == '0) begin
            state       <= IDLE;
            out_valid_q <= 1'b1;
            r_q         <= acc_nxt;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            ze_q        <= (acc_nxt == '0);
            err_q       <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
